karatsuba_seq_ctrl: RTL and testbench

KARATSUBA_SEQ_CTRL -- requirements
Module: karatsuba_seq_ctrl

---
 rtl/karatsuba_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_karatsuba_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_ctrl.sv
// karatsuba_seq_ctrl: sequential signed N x N multiplier built on one shared
// (H+1) x (H+1) unsigned multiplier. Magnitudes are split into halves, three
// partial products are requested over successive grants, and the signed
// 2N-bit product is recombined Karatsuba style and held until consumed.
module karatsuba_seq_ctrl #(
    parameter int N = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   result,
    output logic             mul_req,
    input  logic             mul_gnt,
    output logic [N/2:0]     mul_a,
    output logic [N/2:0]     mul_b,
    input  logic [N+1:0]     mul_p
);

    localparam int H  = N / 2;
    localparam int W2 = 2 * N;
    localparam int ZW = N + 2;

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        COMBINE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mag_a_q, mag_a_d;
    logic [N-1:0]    mag_b_q, mag_b_d;
    logic            neg_q, neg_d;
    logic [ZW-1:0]   z0_q, z0_d;
    logic [ZW-1:0]   z1_q, z1_d;
    logic [ZW-1:0]   z2_q, z2_d;
    logic [W2-1:0]   result_q, result_d;

    logic [N-1:0]    abs_a, abs_b;
    logic [ZW-1:0]   mid_m;
    logic [W2-1:0]   prod_p;

    // Operand magnitudes and recombination z2*2^N + (z1-z0-z2)*2^H + z0.
    // The most negative operand maps to 2^(N-1), which still fits N unsigned bits.
    always_comb begin
        abs_a  = a[N-1] ? (~a + N'(1)) : a;
        abs_b  = b[N-1] ? (~b + N'(1)) : b;
        mid_m  = z1_q - z0_q - z2_q;
        prod_p = (W2'(z2_q) << N) + (W2'(mid_m) << H) + W2'(z0_q);
    end

    // Next-state, datapath capture and handshake outputs; reset forces idle outputs.
    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        z0_d      = z0_q;
        z1_d      = z1_q;
        z2_d      = z2_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_req   = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        result    = result_q;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    neg_d   = a[N-1] ^ b[N-1];
                    state_d = MUL_LO;
                end
            end
            MUL_LO: begin
                mul_req = 1'b1;
                mul_a   = {1'b0, mag_a_q[H-1:0]};
                mul_b   = {1'b0, mag_b_q[H-1:0]};
                if (mul_gnt) begin
                    z0_d    = mul_p;
                    state_d = MUL_HI;
                end
            end
            MUL_HI: begin
                mul_req = 1'b1;
                mul_a   = {1'b0, mag_a_q[N-1:H]};
                mul_b   = {1'b0, mag_b_q[N-1:H]};
                if (mul_gnt) begin
                    z2_d    = mul_p;
                    state_d = MUL_MID;
                end
            end
            MUL_MID: begin
                mul_req = 1'b1;
                mul_a   = {1'b0, mag_a_q[H-1:0]} + {1'b0, mag_a_q[N-1:H]};
                mul_b   = {1'b0, mag_b_q[H-1:0]} + {1'b0, mag_b_q[N-1:H]};
                if (mul_gnt) begin
                    z1_d    = mul_p;
                    state_d = COMBINE;
                end
            end
            COMBINE: begin
                result_d = neg_q ? (W2'(0) - prod_p) : prod_p;
                state_d  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            mul_req   = 1'b0;
            mul_a     = '0;
            mul_b     = '0;
            result    = '0;
        end
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            z0_q     <= '0;
            z1_q     <= '0;
            z2_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            z0_q     <= z0_d;
            z1_q     <= z1_d;
            z2_q     <= z2_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// tb_karatsuba_seq_ctrl: directed bench for karatsuba_seq_ctrl with N=128.
// The shared multiplier is modelled as a combinational product; cycle 1 is
// the cycle right after the accepting edge, so DONE shows up as cycle 5.
module tb_karatsuba_seq_ctrl;

    localparam int N  = 128;
    localparam int H  = N / 2;
    localparam int PW = N + 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  result;
    logic            mul_req;
    logic            mul_gnt;
    logic [H:0]      mul_a;
    logic [H:0]      mul_b;
    logic [PW-1:0]   mul_p;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    karatsuba_seq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .mul_req   (mul_req),
        .mul_gnt   (mul_gnt),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p)
    );

    assign mul_p = PW'(mul_a) * PW'(mul_b);

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_in_ready: got %b expected 1", in_ready);
        end
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = {$urandom, $urandom, $urandom, $urandom};
        b        = {$urandom, $urandom, $urandom, $urandom};
        cyc      = 1;
    endtask

    task automatic wait_valid();
        while (out_valid !== 1'b1 && cyc < 60) begin
            step();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mul_gnt   = 1'b1;
        a         = '0;
        b         = '0;
        step();
        step();
        n_vec += 6;
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b expected 0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (mul_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mul_req: got %b expected 0", mul_req); end
        if (mul_a !== '0) begin n_fail++; $display("[TB] FAIL rst_mul_a: got %0h expected 0", mul_a); end
        if (mul_b !== '0) begin n_fail++; $display("[TB] FAIL rst_mul_b: got %0h expected 0", mul_b); end
        if (result !== '0) begin n_fail++; $display("[TB] FAIL rst_result: got %0h expected 0", result); end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        start_op(128'd3, 128'd5);
        wait_valid();
        n_vec += 2;
        if (cyc !== 5) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d expected 5", cyc); end
        if (result !== 256'd15) begin n_fail++; $display("[TB] FAIL basic_result: got %0h expected f", result); end
        step();
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_one_cycle: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_back_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_signs();
        logic [N-1:0]          ta [11];
        logic [N-1:0]          tb [11];
        logic [2*N-1:0]        te [11];
        logic signed [2*N-1:0] sa, sb;
        logic [N-1:0]          min_v, max_v;
        min_v = {1'b1, 127'd0};
        max_v = {1'b0, {127{1'b1}}};
        ta[0] = -128'sd1;       tb[0] = -128'sd1;        te[0] = 256'd1;
        ta[1] = -128'sd7;       tb[1] = 128'd6;          te[1] = -256'sd42;
        ta[2] = 128'd0;         tb[2] = -128'sd5;        te[2] = 256'd0;
        ta[3] = min_v;          tb[3] = min_v;           te[3] = 256'd1 << 254;
        ta[4] = max_v;          tb[4] = max_v;           te[4] = (256'd1 << 254) - (256'd1 << 128) + 256'd1;
        ta[5] = min_v;          tb[5] = max_v;           te[5] = -((256'd1 << 254) - (256'd1 << 127));
        ta[6] = 128'd123456789; tb[6] = -128'sd987654321; te[6] = -256'sd121932631112635269;
        ta[7] = min_v;          tb[7] = 128'd1;          te[7] = -(256'd1 << 127);
        for (int i = 8; i < 11; i++) begin
            ta[i] = {$urandom, $urandom, $urandom, $urandom};
            tb[i] = {$urandom, $urandom, $urandom, $urandom};
            sa    = $signed(ta[i]);
            sb    = $signed(tb[i]);
            te[i] = sa * sb;
        end
        for (int i = 0; i < 11; i++) begin
            start_op(ta[i], tb[i]);
            wait_valid();
            n_vec += 2;
            if (cyc !== 5) begin n_fail++; $display("[TB] FAIL signs_latency[%0d]: got %0d expected 5", i, cyc); end
            if (result !== te[i]) begin n_fail++; $display("[TB] FAIL signs_result[%0d]: got %0h expected %0h", i, result, te[i]); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        start_op(128'd1000, -128'sd3);
        wait_valid();
        n_vec++;
        if (result !== -256'sd3000) begin n_fail++; $display("[TB] FAIL b2b_result0: got %0h expected %0h", result, -256'sd3000); end
        step();
        n_vec++;
        if (in_ready !== 1'b1 || cyc !== 6) begin
            n_fail++;
            $display("[TB] FAIL b2b_ready_cycle6: got ready=%b cycle=%0d expected ready=1 cycle=6", in_ready, cyc);
        end
        start_op(-128'sd1000, -128'sd3000);
        wait_valid();
        n_vec += 2;
        if (cyc !== 5) begin n_fail++; $display("[TB] FAIL b2b_latency1: got %0d expected 5", cyc); end
        if (result !== 256'd3000000) begin n_fail++; $display("[TB] FAIL b2b_result1: got %0h expected %0h", result, 256'd3000000); end
        step();
    endtask

    task automatic test_gnt_stall();
        logic [H:0]     exp_ma, exp_mb;
        logic [2*N-1:0] exp_r;
        exp_ma = 65'd1 << 36;
        exp_mb = 65'd1 << 26;
        exp_r  = -((256'd1 << 190) + (256'd3 << 100) + (256'd7 << 90) + 256'd21);
        start_op((128'd1 << 100) + 128'd7, -((128'd1 << 90) + 128'd3));
        step();
        mul_gnt  = 1'b0;
        in_valid = 1'b1;
        a        = 128'd5;
        b        = 128'd5;
        for (int i = 0; i < 4; i++) begin
            n_vec += 3;
            if (mul_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_mul_req[%0d]: got %b expected 1", i, mul_req); end
            if (mul_a !== exp_ma) begin n_fail++; $display("[TB] FAIL stall_mul_a[%0d]: got %0h expected %0h", i, mul_a, exp_ma); end
            if (mul_b !== exp_mb) begin n_fail++; $display("[TB] FAIL stall_mul_b[%0d]: got %0h expected %0h", i, mul_b, exp_mb); end
            if (i < 3) step();
        end
        mul_gnt  = 1'b1;
        in_valid = 1'b0;
        wait_valid();
        n_vec += 2;
        if (cyc !== 8) begin n_fail++; $display("[TB] FAIL stall_latency: got %0d expected 8", cyc); end
        if (result !== exp_r) begin n_fail++; $display("[TB] FAIL stall_result: got %0h expected %0h", result, exp_r); end
        step();
    endtask

    task automatic test_out_stall();
        out_ready = 1'b0;
        start_op(-128'sd9, 128'd9);
        wait_valid();
        n_vec += 2;
        if (cyc !== 5) begin n_fail++; $display("[TB] FAIL ostall_latency: got %0d expected 5", cyc); end
        if (result !== -256'sd81) begin n_fail++; $display("[TB] FAIL ostall_result: got %0h expected %0h", result, -256'sd81); end
        in_valid = 1'b1;
        a        = 128'd100;
        b        = 128'd100;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ostall_valid[%0d]: got %b expected 1", i, out_valid); end
            if (result !== -256'sd81) begin n_fail++; $display("[TB] FAIL ostall_hold[%0d]: got %0h expected %0h", i, result, -256'sd81); end
            if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ostall_in_ready[%0d]: got %b expected 0", i, in_ready); end
            if (mul_req !== 1'b0) begin n_fail++; $display("[TB] FAIL ostall_mul_req[%0d]: got %b expected 0", i, mul_req); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ostall_release: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ostall_not_captured: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int seen;
        start_op(128'd11, 128'd13);
        step();
        step();
        rst = 1'b1;
        #1;
        n_vec += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", out_valid); end
        if (mul_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_mul_req: got %b expected 0", mul_req); end
        if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("[TB] FAIL rmid_mul_ab: got %0h/%0h expected 0/0", mul_a, mul_b); end
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_in_ready: got %b expected 0", in_ready); end
        if (result !== '0) begin n_fail++; $display("[TB] FAIL rmid_result: got %0h expected 0", result); end
        step();
        rst = 1'b0;
        #1;
        n_vec += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_release_ready: got %b expected 1", in_ready); end
        if (result !== '0) begin n_fail++; $display("[TB] FAIL rmid_release_result: got %0h expected 0", result); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_fail++; $display("[TB] FAIL rmid_no_pulse: got %0d expected 0", seen); end
        start_op(128'd2, -128'sd3);
        wait_valid();
        n_vec += 2;
        if (cyc !== 5) begin n_fail++; $display("[TB] FAIL rmid_latency: got %0d expected 5", cyc); end
        if (result !== -256'sd6) begin n_fail++; $display("[TB] FAIL rmid_next_result: got %0h expected %0h", result, -256'sd6); end
        step();
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_back_to_back();
        test_gnt_stall();
        test_out_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
